cla_nibble_seq: RTL
===================

// Module: cla_nibble_seq
// PURPOSE
//  Multi-cycle WIDTH-bit adder controller built around one shared 4-bit carry look-ahead slice.
//  - Accepts operands over a valid/ready handshake.
//  - Processes one nibble per clock, LSB nibble first, carrying C3 of each nibble into the next.
//  - Presents sum/carry/overflow over a valid/ready handshake.
//  - Serves as the area-lean wide adder in front of the team's 4-bit CLA datapath.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of 4 and >= 4
//  NIB    WIDTH/4 (localparam)  nibble count = RUN-state cycles per operation
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry into bit 0
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  registered result
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow = carry into MSB XOR cout
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; nibble counter=0.
//    - sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1.
//    - An in-flight operation is discarded with no partial result visible.
//  - FSM IDLE -> RUN -> DONE -> IDLE. All outputs registered or decoded from state only;
//    no combinational path from inputs to outputs.
//  - IDLE: in_ready=1. On in_valid&&in_ready:
//    - latch a, b, cin into internal registers; cnt=0; go to RUN.
//    - Later changes on a/b/cin are ignored until the next accept.
//  - RUN: per cycle, slice k=cnt.
//    - Form g=a_r[4k+3:4k] & b_r[4k+3:4k] and p=a_r[4k+3:4k] ^ b_r[4k+3:4k].
//    - Compute look-ahead carries c0..c3 from g, p and carry_r.
//    - Write sum nibble = p ^ {c2,c1,c0,carry_r}; carry_r <= c3; cnt <= cnt+1.
//    - On the cycle k=NIB-1: cout <= c3; ovf <= c2^c3; go to DONE.
//  - Latency: out_valid rises exactly NIB clocks after the accept edge (4 clocks at WIDTH=16).
//  - Throughput: one operation per NIB+2 clocks when out_ready is held high.
//  - DONE: out_valid=1, in_ready=0. sum/cout/ovf stay stable until out_valid&&out_ready,
//    then go to IDLE.
//    - out_ready high in the first DONE cycle is legal.
//    - There is no same-cycle re-accept: a new operand is taken one cycle later.
//  - out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
//  - Arithmetic is modulo 2^WIDTH; cout carries the extra bit.
//  - Carry ripples correctly across all nibble boundaries, e.g. FFFF+1.
//  - WIDTH=4: single RUN cycle; cnt is 1 bit wide and never wraps.
// CONFIGURATION
//  CLA_SEQ_SUB_EN defined:
//    - Adds input port sub (1 bit), latched at accept.
//    - sub=1 stores b_r=~b and forces carry_r=1 (cin ignored), so sum=a-b.
//    - cout=1 means no borrow; ovf is signed subtract overflow.
//  CLA_SEQ_SUB_EN undefined: no sub port; add only, cin used as given.
// TESTING (WIDTH=16)
//  - a=0x1234, b=0x4321, cin=0 -> out_valid 4 clocks after accept; sum=0x5555, cout=0, ovf=0.
//  - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry through all 4 nibbles).
//  - a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
//  - out_ready low for 3 DONE cycles; a/b toggled meanwhile
//    -> sum/cout stable, in_ready=0 throughout; IDLE 1 clock after out_ready.
//  - rst pulsed during the 2nd RUN cycle -> outputs zero and in_ready=1 immediately;
//    the next op (0x0001+0x0001) gives sum=0x0002.
//  - CLA_SEQ_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0;
//    sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.

Source files
------------

// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq: WIDTH-bit adder built from one shared 4-bit carry look-ahead slice.
// One nibble per clock, LSB nibble first, valid/ready on both operand and result sides.
// Optional subtract mode: define CLA_SEQ_SUB_EN to add the 'sub' input port.
module cla_nibble_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    cnt;

  logic [3:0]       a_n;
  logic [3:0]       b_n;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [3:0]       c;
  logic             last;

  // Shared 4-bit look-ahead slice operating on nibble cnt of the latched operands
  always_comb begin
    a_n  = a_r[{cnt, 2'b00} +: 4];
    b_n  = b_r[{cnt, 2'b00} +: 4];
    g    = a_n & b_n;
    p    = a_n ^ b_n;
    c[0] = g[0] | (p[0] & carry_r);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_r);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & carry_r);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (&p & carry_r);
    last = (cnt == CW'(NIB - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; handshake outputs decode from the state register only
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-nibble sum write-back and final flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            cnt <= '0;
`ifdef CLA_SEQ_SUB_EN
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
`else
            b_r     <= b;
            carry_r <= cin;
`endif
          end
        end
        RUN: begin
          sum[{cnt, 2'b00} +: 4] <= p ^ {c[2:0], carry_r};
          carry_r                <= c[3];
          // cnt holds on the final nibble so a 1-bit counter never wraps
          if (last) begin
            cout <= c[3];
            ovf  <= c[2] ^ c[3];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
